// File: rtl/conv_window_loader_if.sv
// Pixel-stream, convolution-control and window-buffer signals of the 5x5 window loader.
// master = loader side, slave = pixel source / convolution side.
interface conv_window_loader_if #(
  parameter int IMG_W = 32,
  parameter int ROW_W = 6
) ();
  logic                   pix_valid;
  logic [7:0]             pix_data;
  logic                   pix_sof;
  logic                   pix_ready;
  logic                   conv_start;
  logic                   conv_done;
  logic [5*IMG_W-1:0][7:0] win_buf;
  logic [ROW_W-1:0]       win_top_row;
  logic                   frame_done;

  modport master (
    input  pix_valid, pix_data, pix_sof, conv_done,
    output pix_ready, conv_start, win_buf, win_top_row, frame_done
  );

  modport slave (
    output pix_valid, pix_data, pix_sof, conv_done,
    input  pix_ready, conv_start, win_buf, win_top_row, frame_done
  );
endinterface

// File: rtl/conv_window_loader.sv
// Builds 5-row sliding windows from a raster pixel stream for the 5x5 Gaussian stage.
// Define WIN_PREFETCH_EN to stage the next row while the convolution is running.
module conv_window_loader #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int ROW_W = 6
) (
  input logic                  clk,
  input logic                  reset,
  conv_window_loader_if.master bus
);
  localparam int WIN_N = 5 * IMG_W;
  localparam int IDX_W = $clog2(WIN_N);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_TOP = ROW_W'(IMG_H - 5);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_SHIFT, S_REFILL} stateT;

  stateT                   state, stateNext;
  logic [WIN_N-1:0][7:0]   winBuf;
  logic [IMG_W-1:0][7:0]   shiftRow;
  logic [COL_W-1:0]        col, shiftCol;
  logic [2:0]              row;
  logic [ROW_W-1:0]        winTopRow;
  logic                    doneQ, frameDone;
  logic                    readyComb, take, doneRise, lastWin, fillEnd;
  logic                    restartWait, shiftToStart;
  logic [7:0]              restartData;
  logic [IDX_W-1:0]        fillIdx, refillIdx;

  assign take      = bus.pix_valid && readyComb;
  assign doneRise  = bus.conv_done && !doneQ;
  assign lastWin   = (winTopRow == LAST_TOP);
  assign fillEnd   = (row == 3'd4) && (col == LAST_COL);
  assign fillIdx   = IDX_W'(int'(row) * IMG_W + int'(col));
  assign refillIdx = IDX_W'(4 * IMG_W + int'(col));

`ifdef WIN_PREFETCH_EN
  localparam int CIDX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [IMG_W-1:0][7:0] stageRow;
  logic [COL_W-1:0]      stageCnt;
  logic                  restartPend;
  logic [7:0]            restartPix;
  logic                  stageFull;

  assign stageFull    = (stageCnt == COL_W'(IMG_W));
  // A sof taken in the very cycle of done_rise still restarts the frame.
  assign restartWait  = restartPend || (take && bus.pix_sof);
  assign restartData  = restartPend ? restartPix : bus.pix_data;
  assign shiftToStart = stageFull;
  assign shiftRow     = stageRow;
  assign shiftCol     = stageCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageRow    <= '0;
      stageCnt    <= '0;
      restartPend <= 1'b0;
      restartPix  <= '0;
    end else if (state == S_WAIT) begin
      if (doneRise && (restartWait || lastWin)) begin
        stageCnt    <= '0;
        restartPend <= 1'b0;
      end else if (take) begin
        if (bus.pix_sof) begin
          restartPend <= 1'b1;
          restartPix  <= bus.pix_data;
          stageCnt    <= '0;
        end else begin
          stageRow[CIDX_W'(stageCnt)] <= bus.pix_data;
          stageCnt                    <= stageCnt + 1'b1;
        end
      end
    end else if (state == S_SHIFT) begin
      stageCnt <= '0;
    end
  end
`else
  assign restartWait  = 1'b0;
  assign restartData  = '0;
  assign shiftToStart = 1'b0;
  assign shiftRow     = winBuf[WIN_N-1 -: IMG_W];
  assign shiftCol     = '0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    readyComb = 1'b0;
    unique case (state)
      S_IDLE, S_FILL, S_REFILL: readyComb = 1'b1;
`ifdef WIN_PREFETCH_EN
      S_WAIT:                   readyComb = !stageFull && !restartPend;
`endif
      default:                  readyComb = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE:   if (take && bus.pix_sof) stateNext = S_FILL;
      S_FILL:   if (take && !bus.pix_sof && fillEnd) stateNext = S_START;
      S_START:  stateNext = S_WAIT;
      S_WAIT:   if (doneRise) stateNext = restartWait ? S_FILL : (lastWin ? S_IDLE : S_SHIFT);
      S_SHIFT:  stateNext = shiftToStart ? S_START : S_REFILL;
      S_REFILL: if (take) begin
        if (bus.pix_sof)           stateNext = S_FILL;
        else if (col == LAST_COL)  stateNext = S_START;
      end
      default:  stateNext = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= stateNext;
  end

  // NOTE: the window buffer is reset because its all-zero reset contents are visible on win_buf.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winBuf    <= '0;
      col       <= '0;
      row       <= '0;
      winTopRow <= '0;
      doneQ     <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      doneQ     <= bus.conv_done;
      frameDone <= 1'b0;
      if (take && bus.pix_sof && state != S_WAIT) begin
        winBuf[0] <= bus.pix_data;
        col       <= COL_W'(1);
        row       <= '0;
        winTopRow <= '0;
      end else begin
        unique case (state)
          S_FILL: if (take) begin
            winBuf[fillIdx] <= bus.pix_data;
            // Counters hold at the last index; START follows immediately.
            if (col != LAST_COL) col <= col + 1'b1;
            else if (row != 3'd4) begin
              col <= '0;
              row <= row + 1'b1;
            end
          end
          S_REFILL: if (take) begin
            winBuf[refillIdx] <= bus.pix_data;
            if (col != LAST_COL) col <= col + 1'b1;
          end
          S_WAIT: if (doneRise) begin
            frameDone <= lastWin;
            if (restartWait) begin
              winBuf[0] <= restartData;
              col       <= COL_W'(1);
              row       <= '0;
              winTopRow <= '0;
            end
          end
          S_SHIFT: begin
            winBuf    <= {shiftRow, winBuf[WIN_N-1:IMG_W]};
            winTopRow <= winTopRow + 1'b1;
            col       <= shiftCol;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pix_ready   = readyComb && reset;
  assign bus.conv_start  = (state == S_START);
  assign bus.win_buf     = winBuf;
  assign bus.win_top_row = winTopRow;
  assign bus.frame_done  = frameDone;
endmodule

// File: doc/conv_window_loader.md
Name: conv_window_loader

Overview:
- Producer / initiator side of the 5x5 Gaussian convolution stage. Accepts a raster pixel stream over a valid/ready handshake and builds a 5-row x IMG_W-column window buffer.
- Pulses conv_start and waits for conv_done, then slides the window down one row. Repeats until every window of the frame has been processed.
- Sits between the pixel source and the convolution block. Drives that block's buffer input and start; consumes its done.

Parameters:
- IMG_W, 32, pixels per row; window buffer holds 5*IMG_W bytes.
- IMG_H, 32, rows per frame; windows per frame = IMG_H-4.
- ROW_W, 6, width of row counters, ceil(log2(IMG_H+1)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- pix_valid  in  1  source has a pixel.
- pix_data  in  8  pixel value.
- pix_sof  in  1  qualifies the first pixel of a frame.
- pix_ready  out  1  loader accepts a pixel this cycle.
- conv_start  out  1  single-cycle start pulse to the convolution block.
- conv_done  in  1  done from the convolution block; may stay high for several cycles.
- win_buf  out  8 x 5*IMG_W  window; index r*IMG_W+c is row r (0 = top), column c.
- win_top_row  out  ROW_W  frame row held in win_buf row 0 for the current window.
- frame_done  out  1  single-cycle pulse after the last window's conv_done.

Behaviour:
- Reset:
  - All outputs and win_buf are 0.
  - State IDLE; counters 0.
  - done_q (previous conv_done) is 0.
- Acceptance: a pixel is taken only when pix_valid && pix_ready.
- done_rise = conv_done && !done_q. done_q is registered every cycle.
- FSM states:
  - IDLE:
    - pix_ready=1.
    - A taken pixel with pix_sof=1 is written to win_buf[0]; col=1, row=0; go to FILL.
    - Taken pixels without sof are discarded.
  - FILL:
    - pix_ready=1.
    - Each taken pixel goes to win_buf[row*IMG_W+col]; col increments and wraps to 0 at IMG_W, incrementing row.
    - After the pixel at index 5*IMG_W-1 is taken, go to START.
    - A taken pixel with pix_sof=1 restarts: it is written to index 0, col=1, row=0, win_top_row=0.
  - START:
    - pix_ready=0; conv_start=1 for exactly this cycle; go to WAIT.
  - WAIT:
    - pix_ready=0; win_buf is frozen (the convolution reads it combinationally).
    - On done_rise:
      - If win_top_row == IMG_H-5: pulse frame_done next cycle and go to IDLE.
      - Otherwise go to SHIFT.
    - conv_done levels that are not a rising edge are ignored.
  - SHIFT:
    - One cycle: rows 1..4 are copied to rows 0..3, win_top_row increments, col=0; go to REFILL.
    - Row 4 keeps stale data until it is overwritten.
  - REFILL:
    - pix_ready=1; taken pixels are written to row 4 at col.
    - After col IMG_W-1 is taken, go to START.
    - pix_sof=1 on a taken pixel: handled as the FILL restart, state FILL.
- Latency:
  - First conv_start occurs the cycle after the 160th pixel is taken (IMG_W=32).
  - Each subsequent conv_start occurs the cycle after the 32nd refill pixel.
  - Minimum gap from done_rise to the next start is 2+IMG_W cycles.
- conv_start is never asserted while in WAIT; it is at most one pulse per window.
- win_top_row range is 0..IMG_H-5 and it never wraps. Row and col counters saturate at their terminal values by construction.
- Asynchronous reset mid-frame returns to the reset state immediately; a partial window is discarded.
- conv_done high during IDLE/FILL/REFILL only updates done_q and has no other effect.

Optional Feature:
- Macro WIN_PREFETCH_EN.
- When defined:
  - An IMG_W-byte staging row buffer plus a staged-count are added.
  - In WAIT, pix_ready=1 while staged-count < IMG_W; taken pixels go to the staging row.
  - In SHIFT, rows 1..4 move to 0..3 and the staging row is copied into row 4.
  - Taking continues in REFILL at col = staged-count. If staged-count == IMG_W, SHIFT goes directly to START, for a minimum 2-cycle done-to-start gap.
  - pix_sof on a staged pixel discards the window; that pixel restarts FILL at index 0 after WAIT exits with no shift.
  - On the last window, staged pixels belong to the next frame only if the first one carried sof; otherwise they are discarded.
- When undefined: behaviour exactly as described above, with pix_ready=0 in WAIT.

Test Plan:
- Fill, IMG_W=32, IMG_H=32:
  - Stimulus: stream pixel value (r*32+c)&255 with sof on the first pixel.
  - Response: conv_start pulses 1 cycle after pixel 160; win_buf[33]=33, win_buf[159]=159; pix_ready=0 until conv_done.
- Slide:
  - Stimulus: pulse conv_done high for 2 cycles 30 cycles after start.
  - Response: exactly one SHIFT; win_top_row=1; after 32 more pixels, win_buf[0]=32, win_buf[128]=(5*32)&255=160; second conv_start occurs.
- Full frame:
  - Stimulus: run all 28 windows, with conv_done asserted 5 cycles after each start.
  - Response: exactly 28 conv_start pulses; frame_done pulses once after the 28th done; state IDLE; win_top_row=27 holds.
- Backpressure / sof:
  - Stimulus: random pix_valid gaps; pixels before sof are discarded; a second sof at pixel 70.
  - Response: the fill restarts; that pixel lands at win_buf[0]; conv_start occurs after 160 more taken pixels.
- Reset mid-WAIT:
  - Stimulus: deassert reset during WAIT.
  - Response: conv_start=0, frame_done=0, pix_ready=0, win_buf all 0 immediately; after release, pix_ready=1 in IDLE.
- WIN_PREFETCH_EN:
  - Stimulus: 32 pixels are offered during WAIT.
  - Response: all are taken; conv_start follows done_rise by 2 cycles; win_buf row 4 equals the staged data.
